// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: XLEN, M-extension funct3 encodings and MDU FSM states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial remainder,
// subtract the divisor if it fits, and shift the resulting quotient bit in.
module mdu_div_step #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  // Remainder stays below the divisor, so the shifted value always fits in XLEN+1 bits.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor_i};
  assign fits    = ~diff[XLEN];

  assign rem_o = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_o = {quo_i[XLEN-2:0], fits};

endmodule

// File: rtl/mdu_ctrl.sv
// RISC-V M-extension multiply/divide unit: iterative divide, shift-add or single-cycle multiply.
// Define MDU_FAST_MUL_EN to use a combinational multiplier instead of the shift-add loop.
module mdu_ctrl #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] result_o
);

  import riscv_pkg::*;

  mdu_state_t      state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            sa_q, sa_d, sb_q, sb_d, byp_q, byp_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, result_q, result_d;

  logic            is_div, sgn_a, sgn_b, sa_in, sb_in, div_zero, ovf;
  logic [XLEN-1:0] abs_a, abs_b, int_min;

  assign is_div   = funct3_i[2];
  assign sgn_a    = funct3_i inside {FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_DIV, FUNCT3_REM};
  assign sgn_b    = funct3_i inside {FUNCT3_MULH, FUNCT3_DIV, FUNCT3_REM};
  assign sa_in    = sgn_a & op_a_i[XLEN-1];
  assign sb_in    = sgn_b & op_b_i[XLEN-1];
  assign abs_a    = sa_in ? -op_a_i : op_a_i;
  assign abs_b    = sb_in ? -op_b_i : op_b_i;
  assign int_min  = {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = (op_b_i == '0);
  assign ovf      = is_div && sgn_b && (op_a_i == int_min) && (op_b_i == '1);

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{sa_in}}, op_a_i} * {{XLEN{sb_in}}, op_b_i};
`endif

  logic [XLEN-1:0] ds_rem, ds_quo;

  mdu_div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_i    (hi_q),
    .quo_i    (lo_q),
    .divisor_i(b_q),
    .rem_o    (ds_rem),
    .quo_o    (ds_quo)
  );

  // Shift-add multiply: hi accumulates, lo holds the remaining multiplier bits.
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi, mul_lo;
  assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
  assign mul_hi  = mul_sum[XLEN:1];
  assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;
  assign prod     = {hi_q, lo_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;
  assign quo_fix  = (sa_q ^ sb_q) ? -lo_q : lo_q;
  assign rem_fix  = sa_q ? -hi_q : hi_q;

  always_comb begin
    final_res = '0;
    unique case (funct3_q)
      FUNCT3_MUL:                             final_res = prod_fix[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:                final_res = quo_fix;
      FUNCT3_REM, FUNCT3_REMU:                final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    byp_d    = byp_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && !flush_i) begin
          state_d  = CALC;
          funct3_d = funct3_i;
          sa_d     = sa_in;
          sb_d     = sb_in;
          b_d      = abs_b;
          hi_d     = '0;
          lo_d     = abs_a;
          cnt_d    = '0;
          byp_d    = 1'b0;
          // Bypassed ops park their answer in hi and finish after one CALC cycle.
          if (is_div && div_zero) begin
            byp_d = 1'b1;
            hi_d  = funct3_i[1] ? op_a_i : '1;
          end else if (ovf) begin
            byp_d = 1'b1;
            hi_d  = funct3_i[1] ? '0 : op_a_i;
          end
`ifdef MDU_FAST_MUL_EN
          else if (!is_div) begin
            byp_d = 1'b1;
            hi_d  = (funct3_i == FUNCT3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
          end
`endif
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (byp_q) begin
          result_d = hi_q;
          state_d  = DONE;
        end else if (cnt_q == 6'(XLEN)) begin
          // Counts 0..XLEN-1 iterate; the extra count applies sign correction.
          result_d = final_res;
          state_d  = DONE;
          cnt_d    = '0;
        end else begin
          if (funct3_q[2]) begin
            hi_d = ds_rem;
            lo_d = ds_quo;
          end else begin
            hi_d = mul_hi;
            lo_d = mul_lo;
          end
          cnt_d = cnt_q + 6'd1;
        end
      end
      DONE: begin
        if (flush_i || rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      funct3_q <= FUNCT3_MUL;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      byp_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      byp_q    <= byp_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == DONE);
  assign result_o    = result_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: results, latencies, backpressure, flush and reset.
module tb_mdu_ctrl;

  localparam int unsigned XLEN = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [2:0]      funct3_i = 3'd0;
  logic [XLEN-1:0] op_a_i = '0;
  logic [XLEN-1:0] op_b_i = '0;
  logic            flush_i = 1'b0;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b1;
  logic [XLEN-1:0] result_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(
    .XLEN(XLEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .funct3_i   (funct3_i),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .flush_i    (flush_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .result_o   (result_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the unit idle; accept happens on the next edge.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int k;
    funct3_i    = f;
    op_a_i      = a;
    op_b_i      = b;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    k = 0;
    while (!rsp_valid_o && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(lat));
    check({tag, " result"}, result_o, exp);
    if (rsp_ready_i) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int hits;
    hits = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rsp_valid_o) hits++;
    end
    check(tag, 32'(hits), 32'd0);
  endtask

  initial begin
    #2;
    check("reset req_ready", 32'(req_ready_o), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("reset result", result_o, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    do_op("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    do_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("DIV 7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    do_op("REM 7/-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    do_op("DIV 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("REM 5/0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    do_op("DIVU 9/0", 3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    do_op("DIVU no ovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    do_op("DIVU max/1", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

    do_op("MULH -1*-1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, MulLat);
    do_op("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat);
    do_op("MULHSU -1*max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat);
    do_op("MUL max*max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, MulLat);
    do_op("MUL 7*6", 3'b000, 32'd7, 32'd6, 32'd42, MulLat);
    do_op("MULH min*2", 3'b001, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, MulLat);

    // Backpressure: response must hold while the consumer stalls.
    rsp_ready_i = 1'b0;
    do_op("stall DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall rsp_valid", 32'(rsp_valid_o), 32'd1);
      check("stall result", result_o, 32'd14);
      check("stall req_ready", 32'(req_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("post-stall rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("post-stall req_ready", 32'(req_ready_o), 32'd1);

    // Flush while idle suppresses the accept.
    funct3_i    = 3'b101;
    op_a_i      = 32'd100;
    op_b_i      = 32'd7;
    req_valid_i = 1'b1;
    flush_i     = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    check("idle flush req_ready", 32'(req_ready_o), 32'd1);

    // Flush at CALC cycle 10.
    req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    check("calc req_ready", 32'(req_ready_o), 32'd0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush req_ready", 32'(req_ready_o), 32'd1);
    check("flush rsp_valid", 32'(rsp_valid_o), 32'd0);
    watch_quiet("flush no response", 40);

    // Reset pulse mid-divide.
    req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("midop reset req_ready", 32'(req_ready_o), 32'd1);
    check("midop reset rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("midop reset result", result_o, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    watch_quiet("reset no response", 40);
    check("post-reset req_ready", 32'(req_ready_o), 32'd1);

    do_op("DIVU after reset", 3'b101, 32'd1000, 32'd10, 32'd100, 33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
